lif_stdp_pair: RTL
==================

LIF_STDP_PAIR -- requirements
Module: lif_stdp_pair

Interface
REQ-001 SHALL have parameter W, default 8: membrane state and input current width.
REQ-002 SHALL have parameter WW, default 8: weight width; WW <= W is required.
REQ-003 SHALL have parameter THRESH, default 200: spike threshold, compared as state >= THRESH.
REQ-004 SHALL have parameter LEAK_SHIFT, default 3: leak equals state >> LEAK_SHIFT.
REQ-005 SHALL have parameter REFRAC, default 2: refractory cycles after a spike.
REQ-006 SHALL have parameters WIN (default 8), A_PLUS (default 16), A_MINUS (default 8) and W_INIT (default 64): the STDP window and learning amounts.
REQ-007 SHALL have a single clock, clk (input, 1), rising edge only.
REQ-008 SHALL have rst (input, 1): reset, synchronous and active-high.
REQ-009 SHALL have pre_current (input, W): drive into the presynaptic neuron.
REQ-010 SHALL have post_current (input, W): external drive into the postsynaptic neuron.
REQ-011 SHALL have learn_en (input, 1): enables weight updates.
REQ-012 SHALL have pre_spike and post_spike (outputs, 1 each): one-cycle spike pulses.
REQ-013 SHALL have pre_state and post_state (outputs, W each): membrane potentials.
REQ-014 SHALL have weight (output, WW): synaptic weight.
REQ-015 SHALL have w_upd (output, 1): pulses high for one cycle when weight changes.
REQ-016 SHALL have w_dir (output, 1): 1 for potentiation and 0 for depression, valid with w_upd.

Function
REQ-017 SHALL implement two identical LIF neurons with registered state, spike and refractory counter.
REQ-018 SHALL evaluate three cases per neuron per cycle, in priority order:
- refrac > 0: decrement refrac; state <= 0; spike <= 0.
- else state >= THRESH: spike <= 1; state <= 0; refrac <= REFRAC.
- else: spike <= 0; state <= sat(state - (state >> LEAK_SHIFT) + I).
REQ-019 SHALL compute the next-state sum in W+1 bits and saturate it to 2^W-1.
REQ-020 SHALL use I = pre_current for the presynaptic neuron.
REQ-021 SHALL use I = sat(post_current + (pre_spike ? weight zero-extended : 0)) for the postsynaptic neuron.
REQ-022 SHALL give a spike latency of one cycle: spike is high in the cycle after the state register first holds a value >= THRESH.
REQ-023 SHALL keep a spike-age timer per neuron (pre_dt, post_dt; width clog2(WIN+1)).
- The timer loads 0 on a cycle where its own spike is high.
- Otherwise it increments, saturating at WIN; WIN means "no recent spike".
REQ-024 SHALL apply LTP when post_spike & !pre_spike & learn_en & pre_dt < WIN: weight <= min(weight + (A_PLUS >> pre_dt), 2^WW-1).
REQ-025 SHALL apply LTD when pre_spike & !post_spike & learn_en & post_dt < WIN: weight <= max(weight - (A_MINUS >> post_dt), 0).
REQ-026 SHALL leave weight unchanged when pre_spike and post_spike are high in the same cycle.
REQ-027 SHALL use the pre-update register values of pre_dt and post_dt in the REQ-024/025 decisions.
REQ-028 SHALL assert w_upd together with the new weight value only if the weight value actually changed; a saturated no-change gives w_upd = 0.
REQ-029 SHALL hold the weight when learn_en = 0; the timers keep running.

Reset
REQ-030 SHALL, on rst = 1 at a clock edge, clear both states, spikes and refractory counters to 0.
REQ-031 SHALL, on the same reset, set pre_dt = post_dt = WIN, weight = W_INIT, and w_upd = w_dir = 0.
REQ-032 SHALL let reset asserted mid-refractory or mid-update take priority over all other behaviour.

Configuration
REQ-033 SHALL use macro STDP_LEARN_EN to compile the learning logic in or out.
REQ-034 SHALL, when STDP_LEARN_EN is defined, implement timers and learning as REQ-023 to REQ-029.
REQ-035 SHALL, when STDP_LEARN_EN is undefined:
- omit timers and update logic;
- hold weight constant at W_INIT;
- drive w_upd = w_dir = 0;
- ignore learn_en.

Verification (default parameters)
REQ-036 SHALL cover reset: pulse rst with inputs at 0 -> all states and spikes 0, weight = 64, w_upd = 0.
REQ-037 SHALL cover firing: hold pre_current = 255 after reset -> pre_state = 255 at edge 1 and pre_spike high after edges 2, 6, 10 (period 4), pre_state = 0 during refractory.
REQ-038 SHALL cover LTP: post_spike one cycle after pre_spike (pre_dt = 0) -> weight 64 -> 80 with w_upd = 1, w_dir = 1; repeat with a three-cycle lag from reset (pre_dt = 2) -> 64 -> 68.
REQ-039 SHALL cover LTD: pre_spike two cycles after post_spike (post_dt = 1) -> weight 64 -> 60 with w_upd = 1, w_dir = 0.
REQ-040 SHALL cover simultaneous spikes and saturation:
- pre and post spike in the same cycle -> weight unchanged, w_upd = 0;
- weight at 255 followed by LTP -> weight stays 255, w_upd = 0.
REQ-041 SHALL cover the learning disable: learn_en = 0, or STDP_LEARN_EN undefined, under scenario REQ-038 -> weight stays 64 and w_upd is never asserted.

Source files
------------

// File: rtl/lif_stdp_pair.sv
// Two leaky integrate-and-fire neurons, the presynaptic one driving the postsynaptic one through a plastic synapse.
// The pair-based STDP weight learning is compiled in only when STDP_LEARN_EN is defined; otherwise the weight stays at W_INIT.
module lif_stdp_pair #(
    parameter int W          = 8,
    parameter int WW         = 8,
    parameter int THRESH     = 200,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int WIN        = 8,
    parameter int A_PLUS     = 16,
    parameter int A_MINUS    = 8,
    parameter int W_INIT     = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  pre_current,
    input  logic [W-1:0]  post_current,
    input  logic          learn_en,
    output logic          pre_spike,
    output logic          post_spike,
    output logic [W-1:0]  pre_state,
    output logic [W-1:0]  post_state,
    output logic [WW-1:0] weight,
    output logic          w_upd,
    output logic          w_dir
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [W-1:0]  TH     = W'(THRESH);
    localparam logic [RW-1:0] RF     = RW'(REFRAC);
    localparam logic [WW-1:0] W_RST  = WW'(W_INIT);

    logic [RW-1:0] pre_ref;
    logic [RW-1:0] post_ref;
    logic [W-1:0]  post_in;
    logic [W-1:0]  pre_next;
    logic [W-1:0]  post_next;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? '1 : s[W-1:0];
    endfunction

    // state - leak never underflows, and the sum of two W-bit terms fits in W+1 bits
    function automatic logic [W-1:0] lif_next(input logic [W-1:0] s, input logic [W-1:0] i);
        logic [W:0] sum;
        sum = {1'b0, s} - ({1'b0, s} >> LEAK_SHIFT) + {1'b0, i};
        return sum[W] ? '1 : sum[W-1:0];
    endfunction

    always_comb begin
        post_in   = sat_add(post_current, pre_spike ? W'(weight) : '0);
        pre_next  = lif_next(pre_state, pre_current);
        post_next = lif_next(post_state, post_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_state  <= '0;
            pre_spike  <= 1'b0;
            pre_ref    <= '0;
            post_state <= '0;
            post_spike <= 1'b0;
            post_ref   <= '0;
        end else begin
            if (pre_ref != '0) begin
                pre_ref   <= pre_ref - RW'(1);
                pre_state <= '0;
                pre_spike <= 1'b0;
            end else if (pre_state >= TH) begin
                pre_spike <= 1'b1;
                pre_state <= '0;
                pre_ref   <= RF;
            end else begin
                pre_spike <= 1'b0;
                pre_state <= pre_next;
            end

            if (post_ref != '0) begin
                post_ref   <= post_ref - RW'(1);
                post_state <= '0;
                post_spike <= 1'b0;
            end else if (post_state >= TH) begin
                post_spike <= 1'b1;
                post_state <= '0;
                post_ref   <= RF;
            end else begin
                post_spike <= 1'b0;
                post_state <= post_next;
            end
        end
    end

`ifdef STDP_LEARN_EN
    localparam int DW = $clog2(WIN + 1);
    localparam logic [DW-1:0] DT_MAX = DW'(WIN);

    logic [DW-1:0] pre_dt;
    logic [DW-1:0] post_dt;
    logic          ltp;
    logic          ltd;
    logic [WW:0]   ltp_amt;
    logic [WW:0]   ltd_amt;
    logic [WW:0]   w_inc;
    logic [WW-1:0] w_plus;
    logic [WW-1:0] w_minus;
    logic [WW-1:0] w_next;

    // decisions use the timer values from before this edge's update
    always_comb begin
        ltp     = post_spike & ~pre_spike & learn_en & (pre_dt < DT_MAX);
        ltd     = pre_spike & ~post_spike & learn_en & (post_dt < DT_MAX);
        ltp_amt = (WW+1)'(A_PLUS >> pre_dt);
        ltd_amt = (WW+1)'(A_MINUS >> post_dt);
        w_inc   = {1'b0, weight} + ltp_amt;
        w_plus  = w_inc[WW] ? '1 : w_inc[WW-1:0];
        w_minus = ({1'b0, weight} < ltd_amt) ? '0 : weight - ltd_amt[WW-1:0];
        w_next  = weight;
        if (ltp)
            w_next = w_plus;
        else if (ltd)
            w_next = w_minus;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_dt  <= DT_MAX;
            post_dt <= DT_MAX;
            weight  <= W_RST;
            w_upd   <= 1'b0;
            w_dir   <= 1'b0;
        end else begin
            pre_dt  <= pre_spike  ? '0 : ((pre_dt == DT_MAX)  ? DT_MAX : pre_dt + DW'(1));
            post_dt <= post_spike ? '0 : ((post_dt == DT_MAX) ? DT_MAX : post_dt + DW'(1));
            weight  <= w_next;
            w_upd   <= (w_next != weight);
            w_dir   <= ltp & (w_next != weight);
        end
    end
`else
    logic unused_learn_en;
    assign unused_learn_en = learn_en;
    assign weight = W_RST;
    assign w_upd  = 1'b0;
    assign w_dir  = 1'b0;
`endif

endmodule
